// File: rtl/inequality_window_tracker.sv
// Classifies unsigned samples against programmable LO/HI thresholds and
// debounces the resulting zone, counting committed zone transitions.
module inequality_window_tracker #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8,
    parameter int LO_RST   = 5,
    parameter int HI_RST   = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_cfg_we,
    input  logic [WIDTH-1:0] i_cfg_lo,
    input  logic [WIDTH-1:0] i_cfg_hi,
    output logic             o_cfg_err,
    output logic [2:0]       o_cmp,
    output logic [2:0]       o_zone,
    output logic             o_zone_chg,
    output logic [CNT_W-1:0] o_trans_cnt
);

    typedef enum logic [2:0] {
        ZONE_BELOW  = 3'b001,
        ZONE_INSIDE = 3'b010,
        ZONE_ABOVE  = 3'b100
    } zone_t;

    localparam logic [4:0]       DEB     = 5'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic zone_t classify(input logic [WIDTH-1:0] d,
                                       input logic [WIDTH-1:0] lo,
                                       input logic [WIDTH-1:0] hi);
        zone_t z;
        if (d > hi) begin
            z = ZONE_ABOVE;
        end else if (d < lo) begin
            z = ZONE_BELOW;
        end else begin
            z = ZONE_INSIDE;
        end
        return z;
    endfunction

    logic [WIDTH-1:0] r_lo, r_hi;
    zone_t            r_cmp, r_zone, r_pend_zone;
    logic [3:0]       r_pend_cnt;
    logic             r_zone_chg, r_cfg_err;
    logic [CNT_W-1:0] r_trans_cnt;

    logic [WIDTH-1:0] w_lo_nxt, w_hi_nxt;
    zone_t            w_cmp_nxt, w_zone_nxt, w_pend_zone_nxt, w_class;
    logic [3:0]       w_pend_cnt_nxt;
    logic             w_zone_chg_nxt, w_cfg_ok, w_cfg_bad;
    logic [CNT_W-1:0] w_trans_cnt_nxt;
    logic [4:0]       w_run_next;

    assign w_cfg_ok   = i_cfg_we && (i_cfg_lo <= i_cfg_hi);
    assign w_cfg_bad  = i_cfg_we && (i_cfg_lo > i_cfg_hi);
    assign w_class    = classify(i_in_data, r_lo, r_hi);
    assign w_run_next = {1'b0, r_pend_cnt} + 5'd1;

    // Next-state: config update, classification and debounce commit
    always_comb begin
        w_lo_nxt        = r_lo;
        w_hi_nxt        = r_hi;
        w_cmp_nxt       = r_cmp;
        w_zone_nxt      = r_zone;
        w_pend_zone_nxt = r_pend_zone;
        w_pend_cnt_nxt  = r_pend_cnt;
        w_zone_chg_nxt  = 1'b0;
        w_trans_cnt_nxt = r_trans_cnt;
        if (w_cfg_ok) begin
            // An accepted write restarts debouncing and drops the same-cycle sample.
            w_lo_nxt       = i_cfg_lo;
            w_hi_nxt       = i_cfg_hi;
            w_pend_cnt_nxt = 4'd0;
        end else if (i_in_valid) begin
            w_cmp_nxt = w_class;
            if (w_class == r_zone) begin
                w_pend_cnt_nxt = 4'd0;
            end else if ((w_class == r_pend_zone) || (DEB == 5'd1)) begin
                w_pend_zone_nxt = w_class;
                if ((w_class != r_pend_zone) || (w_run_next == DEB)) begin
                    w_zone_nxt     = w_class;
                    w_zone_chg_nxt = 1'b1;
                    w_pend_cnt_nxt = 4'd0;
                    if (r_trans_cnt != CNT_MAX) begin
                        w_trans_cnt_nxt = r_trans_cnt + CNT_W'(1);
                    end else begin
                        w_trans_cnt_nxt = r_trans_cnt;
                    end
                end else begin
                    w_pend_cnt_nxt = w_run_next[3:0];
                end
            end else begin
                w_pend_zone_nxt = w_class;
                w_pend_cnt_nxt  = 4'd1;
            end
        end else begin
            w_pend_cnt_nxt = r_pend_cnt;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lo        <= WIDTH'(LO_RST);
            r_hi        <= WIDTH'(HI_RST);
            r_cmp       <= ZONE_INSIDE;
            r_zone      <= ZONE_INSIDE;
            r_pend_zone <= ZONE_INSIDE;
            r_pend_cnt  <= 4'd0;
            r_zone_chg  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_trans_cnt <= '0;
        end else begin
            r_lo        <= w_lo_nxt;
            r_hi        <= w_hi_nxt;
            r_cmp       <= w_cmp_nxt;
            r_zone      <= w_zone_nxt;
            r_pend_zone <= w_pend_zone_nxt;
            r_pend_cnt  <= w_pend_cnt_nxt;
            r_zone_chg  <= w_zone_chg_nxt;
            r_cfg_err   <= w_cfg_bad;
            r_trans_cnt <= w_trans_cnt_nxt;
        end
    end

    assign o_cfg_err   = r_cfg_err;
    assign o_cmp       = r_cmp;
    assign o_zone      = r_zone;
    assign o_zone_chg  = r_zone_chg;
    assign o_trans_cnt = r_trans_cnt;

endmodule

// File: doc/inequality_window_tracker.md
Name: inequality_window_tracker

Overview:
Parametrised, clocked successor to the team's combinational inequality decoder. It classifies a stream of unsigned WIDTH-bit samples against programmable low/high thresholds into BELOW / INSIDE / ABOVE. A debounce state machine commits a zone change only after DEBOUNCE consecutive agreeing samples, and a saturating counter tracks committed transitions. It sits after sample capture and drives alarm/status logic.

Parameters:
WIDTH, 4, sample and threshold width in bits (>=2)
DEBOUNCE, 3, consecutive valid samples needed to commit a zone change (1..15)
CNT_W, 8, width of the transition counter
LO_RST, 5, threshold LO after reset
HI_RST, 10, threshold HI after reset

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  IN_DATA holds a sample this cycle
IN_DATA  input  WIDTH  unsigned sample
CFG_WE  input  1  write request for the thresholds
CFG_LO  input  WIDTH  new low threshold
CFG_HI  input  WIDTH  new high threshold
CFG_ERR  output  1  one-cycle pulse: config write rejected
CMP  output  3  registered raw class of the last valid sample: {>HI, LO..HI inclusive, <LO}; always one-hot
ZONE  output  3  debounced zone, one-hot, same bit order as CMP
ZONE_CHG  output  1  one-cycle pulse when ZONE changes
TRANS_CNT  output  CNT_W  committed transitions, saturating

Behaviour:
- Reset is asynchronous on RST_N=0 and sets:
  - CMP=3'b010, ZONE=3'b010 (INSIDE), ZONE_CHG=0, CFG_ERR=0, TRANS_CNT=0.
  - LO=LO_RST, HI=HI_RST.
  - pend_zone=INSIDE, pend_cnt=0.
  - Reset mid-sequence discards pending progress. The first edge after deassertion is a normal cycle.
- Classification, c (combinational, current LO/HI):
  - ABOVE if IN_DATA>HI.
  - BELOW if IN_DATA<LO.
  - Otherwise INSIDE; LO==HI is a legal single-value window.
- Config:
  - CFG_WE=1 with CFG_LO<=CFG_HI: accepted. LO/HI update at the edge, pend_cnt clears, and any sample in that cycle is discarded (CMP and state unchanged).
  - CFG_WE=1 with CFG_LO>CFG_HI: rejected. Thresholds are unchanged, CFG_ERR=1 for the next cycle, and a same-cycle sample is processed normally with the old thresholds.
  - ZONE is not re-evaluated by a config write; it changes only through new samples.
- Per valid sample (IN_VALID=1, no accepted config):
  - CMP<=c (one-cycle latency).
  - If c==ZONE: pend_cnt<=0.
  - Else if c==pend_zone and pend_cnt+1==DEBOUNCE: ZONE<=c, ZONE_CHG<=1, pend_cnt<=0, and TRANS_CNT increments.
  - Else if c==pend_zone: pend_cnt<=pend_cnt+1.
  - Else: pend_zone<=c and pend_cnt<=1. If DEBOUNCE==1, commit immediately as above.
- ZONE_CHG is high for exactly one cycle per commit.
- IN_VALID=0 cycles hold all state; gaps do not break a run. CMP holds its last value.
- ZONE may jump directly BELOW<->ABOVE; that counts as one transition.
- TRANS_CNT saturates at 2^CNT_W-1: further commits still pulse ZONE_CHG but do not wrap the counter.
- Commit latency: ZONE updates on the edge that samples the DEBOUNCE-th agreeing sample.
- CMP and ZONE are always one-hot; a bench assertion checks this every cycle.

Test Plan:
1. Reset release, with WIDTH=4, LO=5, HI=10, DEBOUNCE=3 (applies to all scenarios) -> ZONE=010, CMP=010, TRANS_CNT=0, CFG_ERR=0.
2. Three valid samples of 14 in consecutive cycles -> CMP=100 after the first edge. ZONE=100 and ZONE_CHG=1 after the third edge only; TRANS_CNT=1.
3. Samples 14, 14, 7, 14, 14 starting from INSIDE -> the 7 resets the run and ZONE stays 010. Now add idle cycles between two more 14s -> commit on the third agreeing 14, idles ignored.
4. Config writes:
   - CFG_WE with LO=12, HI=3 -> CFG_ERR pulses one cycle and thresholds stay 5/10; a same-cycle sample of 2 still sets CMP=001.
   - CFG_WE with LO=10, HI=10 -> accepted; a same-cycle sample is discarded and CMP is unchanged. A later sample of 10 -> CMP=010.
5. From ZONE=ABOVE, three samples of 0 -> ZONE=001 directly, one ZONE_CHG, TRANS_CNT+1. With CNT_W=2, drive 5 commits -> TRANS_CNT stops at 3 while ZONE_CHG still pulses 5 times.
6. Assert RST_N=0 asynchronously between edges after two agreeing 14s -> outputs reset immediately. After release, one 14 does not commit; a fresh run of 3 is required.
